// File: rtl/cfg_loader_pkg.sv
// Shared types and sizing helpers for the configuration chain loader.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int SEG_BITS_DEFAULT     = 80;
  localparam int DONE_TIMEOUT_DEFAULT = 4;
  localparam int BYTE_W               = 8;
  localparam int BIT_IDX_W            = 3;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_bit_serializer.sv
// Byte holding register that presents one bit at a time, MSB first, on a
// registered serial output.
module cfg_bit_serializer
  import cfg_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [BYTE_W-1:0] data_in,
  output logic              bit_out,
  output logic              empty
);

  logic [BYTE_W-1:0]    byte_q;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic [BIT_IDX_W-1:0] bit_idx_nxt;

  assign bit_idx_nxt = bit_idx - 1'b1;
  assign empty       = (bit_idx == '0);

  // bit_out always mirrors byte_q[bit_idx], so it is updated together with the index.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_q  <= '0;
      bit_idx <= '0;
      bit_out <= 1'b0;
    end else if (load) begin
      byte_q  <= data_in;
      bit_idx <= BIT_IDX_W'(BYTE_W - 1);
      bit_out <= data_in[BYTE_W-1];
    end else if (shift) begin
      bit_idx <= bit_idx_nxt;
      bit_out <= byte_q[bit_idx_nxt];
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Loads a byte-wide bitstream into daisy-chained configuration segments, one
// segment enabled at a time, verifying each segment's done flag.
//
// state | meaning
// IDLE  | waiting for start, prgm_b released
// FETCH | requesting the next bitstream byte, chain stalled
// SHIFT | one bit per cycle into the enabled segment
// CHECK | waiting (bounded) for the finished segment's done flag
// DONE  | one-cycle completion pulse
// ERR   | early or missing done; sets the sticky error flag
module cfg_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int NUM_SEG      = 4,
  parameter int SEG_BITS     = SEG_BITS_DEFAULT,
  parameter int DONE_TIMEOUT = DONE_TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [BYTE_W-1:0]  data_in,
  input  logic               data_valid,
  output logic               data_ready,
  input  logic [NUM_SEG-1:0] seg_done_in,
  output logic               prgm_b,
  output logic [NUM_SEG-1:0] seg_prgm_b,
  output logic               bit_out,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int SEG_CNT_W = cnt_width(SEG_BITS);
  localparam int SEG_IDX_W = cnt_width(NUM_SEG);
  localparam int TMO_W     = cnt_width(DONE_TIMEOUT + 1);

  localparam logic [SEG_CNT_W-1:0] LAST_BIT = SEG_CNT_W'(SEG_BITS - 1);
  localparam logic [SEG_IDX_W-1:0] LAST_SEG = SEG_IDX_W'(NUM_SEG - 1);
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(DONE_TIMEOUT);
  localparam logic [NUM_SEG-1:0]   SEG_ONE  = NUM_SEG'(1);

  state_t               state_q, state_d;
  logic [SEG_IDX_W-1:0] seg_q, seg_d;
  logic [SEG_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 error_q, error_d;
  logic [NUM_SEG-1:0]   seg_en_q, seg_en_d;

  logic ser_load;
  logic ser_shift;
  logic ser_empty;
  logic last_bit;
  logic cur_done;

  cfg_bit_serializer u_ser (
    .clk     (clk),
    .reset   (reset),
    .load    (ser_load),
    .shift   (ser_shift),
    .data_in (data_in),
    .bit_out (bit_out),
    .empty   (ser_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      seg_q     <= '0;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      error_q   <= 1'b0;
      seg_en_q  <= '0;
    end else begin
      state_q   <= state_d;
      seg_q     <= seg_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
      error_q   <= error_d;
      seg_en_q  <= seg_en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    seg_d     = seg_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    error_d   = error_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    last_bit  = (bit_cnt_q == LAST_BIT);
    cur_done  = seg_done_in[seg_q];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_FETCH;
          error_d   = 1'b0;
          seg_d     = '0;
          bit_cnt_d = '0;
          tmo_d     = '0;
        end
      end
      ST_FETCH: begin
        if (data_valid) begin
          ser_load = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        // The final bit wins over the early-done check: a segment may legitimately
        // raise done on the same edge that clocks its last bit in.
        if (last_bit) begin
          state_d = ST_CHECK;
          tmo_d   = TMO_W'(1);
        end else if (cur_done) begin
          state_d = ST_ERR;
        end else if (ser_empty) begin
          state_d = ST_FETCH;
        end else begin
          ser_shift = 1'b1;
        end
      end
      ST_CHECK: begin
        if (cur_done) begin
          if (seg_q == LAST_SEG) begin
            state_d = ST_DONE;
          end else begin
            seg_d     = seg_q + 1'b1;
            bit_cnt_d = '0;
            if (ser_empty) begin
              state_d = ST_FETCH;
            end else begin
              ser_shift = 1'b1;
              state_d   = ST_SHIFT;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_ERR) error_d = 1'b1;

    // Enables are registered, so they are computed for the state being entered.
    seg_en_d = (state_d == ST_SHIFT) ? (SEG_ONE << seg_d) : '0;
  end

  assign data_ready = (state_q == ST_FETCH);
  assign prgm_b     = !((state_q == ST_FETCH) || (state_q == ST_SHIFT) || (state_q == ST_CHECK));
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign error      = error_q;
  assign seg_prgm_b = seg_en_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: a small 2x12 instance for the nominal and
// error scenarios, and a default-parameter instance for reset and full loads.
module tb_cfg_chain_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       chain_clr = 1'b1;

  logic       data_ready_a, prgm_b_a, bit_out_a, busy_a, done_a, error_a;
  logic [1:0] seg_prgm_b_a, seg_done_a;
  logic       data_ready_b, prgm_b_b, bit_out_b, busy_b, done_b, error_b;
  logic [3:0] seg_prgm_b_b, seg_done_b;

  always #5 clk = ~clk;

  cfg_chain_loader #(.NUM_SEG(2), .SEG_BITS(12), .DONE_TIMEOUT(4)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready_a), .seg_done_in(seg_done_a),
    .prgm_b(prgm_b_a), .seg_prgm_b(seg_prgm_b_a), .bit_out(bit_out_a),
    .busy(busy_a), .done(done_a), .error(error_a)
  );

  cfg_chain_loader u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready_b), .seg_done_in(seg_done_b),
    .prgm_b(prgm_b_b), .seg_prgm_b(seg_prgm_b_b), .bit_out(bit_out_b),
    .busy(busy_b), .done(done_b), .error(error_b)
  );

  // Chain models: each segment counts its enabled edges and captures bits.
  int          thr_a [2];
  int          cnt_a [2];
  logic [11:0] cap_a [2];
  int          cnt_b [4];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (chain_clr) begin
        cnt_a[i] <= 0;
        cap_a[i] <= '0;
      end else if (seg_prgm_b_a[i]) begin
        cnt_a[i] <= cnt_a[i] + 1;
        cap_a[i] <= {cap_a[i][10:0], bit_out_a};
      end
    end
    for (int j = 0; j < 4; j++) begin
      if (chain_clr)            cnt_b[j] <= 0;
      else if (seg_prgm_b_b[j]) cnt_b[j] <= cnt_b[j] + 1;
    end
  end

  assign seg_done_a[0] = (cnt_a[0] >= thr_a[0]);
  assign seg_done_a[1] = (cnt_a[1] >= thr_a[1]);
  assign seg_done_b[0] = (cnt_b[0] >= 80);
  assign seg_done_b[1] = (cnt_b[1] >= 80);
  assign seg_done_b[2] = (cnt_b[2] >= 80);
  assign seg_done_b[3] = (cnt_b[3] >= 80);

  // Observation mux for the instance under test.
  bit         sel = 1'b0;
  logic       m_ready, m_prgm, m_busy, m_done, m_error, m_bit;
  logic [3:0] m_seg;
  assign m_ready = sel ? data_ready_b : data_ready_a;
  assign m_prgm  = sel ? prgm_b_b     : prgm_b_a;
  assign m_busy  = sel ? busy_b       : busy_a;
  assign m_done  = sel ? done_b       : done_a;
  assign m_error = sel ? error_b      : error_a;
  assign m_bit   = sel ? bit_out_b    : bit_out_a;
  assign m_seg   = sel ? seg_prgm_b_b : {2'b00, seg_prgm_b_a};

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] stim [40];

  int en_cnt, done_cnt, chk_cyc, stall_cyc, fetch_en, multi, timed_out;
  logic end_error, end_prgm, end_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string who);
    chk({who, "_prgm_b"},     32'(m_prgm),  32'd1);
    chk({who, "_seg_prgm_b"}, 32'(m_seg),   32'd0);
    chk({who, "_bit_out"},    32'(m_bit),   32'd0);
    chk({who, "_data_ready"}, 32'(m_ready), 32'd0);
    chk({who, "_busy"},       32'(m_busy),  32'd0);
    chk({who, "_done"},       32'(m_done),  32'd0);
    chk({who, "_error"},      32'(m_error), 32'd0);
  endtask

  task automatic clear_chain();
    @(negedge clk) chain_clr = 1'b1;
    @(negedge clk) chain_clr = 1'b0;
  endtask

  // Pulses start, then feeds bytes at every negedge until done, error, an
  // injected reset, or the cycle budget.
  task automatic run_load(input int n_bytes, input int stall_k, input int reset_at,
                          input int start_at, input int max_cyc);
    int k          = 0;
    int stall_left = 0;
    bit stall_used = 1'b0;
    bit start_used = 1'b0;
    en_cnt = 0; done_cnt = 0; chk_cyc = 0; stall_cyc = 0;
    fetch_en = 0; multi = 0; timed_out = 1;
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    chk("start_data_ready", 32'(m_ready), 32'd1);
    chk("start_prgm_b",     32'(m_prgm),  32'd0);
    for (int c = 0; c < max_cyc; c++) begin
      if (c > 0) @(negedge clk);
      start_b = 1'b0;
      if (stall_k >= 0 && !stall_used && k == stall_k && m_ready) begin
        stall_left = 10;
        stall_used = 1'b1;
      end
      if (stall_left > 0) begin
        data_valid = 1'b0;
        stall_left--;
      end else if (k < n_bytes) begin
        data_valid = 1'b1;
        data_in    = stim[k];
      end else begin
        data_valid = 1'b0;
      end
      if (m_ready && !data_valid) stall_cyc++;
      if (m_ready && data_valid) k++;
      if (m_done) done_cnt++;
      if (m_seg != 4'd0) en_cnt++;
      if ($countones(m_seg) > 1) multi++;
      if (m_ready && m_seg != 4'd0) fetch_en++;
      if (m_busy && !m_prgm && !m_ready && m_seg == 4'd0) chk_cyc++;
      if (start_at > 0 && !start_used && en_cnt == start_at) begin
        start_b    = 1'b1;
        start_used = 1'b1;
      end
      if (reset_at > 0 && en_cnt == reset_at) begin
        reset = 1'b1;
        timed_out = 0;
        break;
      end
      if (m_done || m_error) begin
        timed_out = 0;
        break;
      end
    end
    end_error = m_error;
    end_prgm  = m_prgm;
    end_busy  = m_busy;
    data_valid = 1'b0;
    start_b    = 1'b0;
    chk("run_bounded", 32'(timed_out), 32'd0);
  endtask

  initial begin
    stim[0] = 8'hA5;
    stim[1] = 8'h3C;
    stim[2] = 8'h0F;
    for (int i = 3; i < 40; i++) stim[i] = 8'(i * 37 + 11);
    thr_a[0] = 12;
    thr_a[1] = 12;

    // Reset state
    repeat (3) @(negedge clk);
    sel = 1'b0;
    check_reset_vals("rst_a");
    reset = 1'b0;
    chain_clr = 1'b0;

    // Nominal load: A5 3C 0F split 12/12
    clear_chain();
    run_load(3, -1, 0, 0, 200);
    chk("nom_seg0",     32'(cap_a[0]), 32'h0A53);
    chk("nom_seg1",     32'(cap_a[1]), 32'h0C0F);
    chk("nom_enables",  32'(en_cnt),   32'd24);
    chk("nom_done",     32'(done_cnt), 32'd1);
    chk("nom_checks",   32'(chk_cyc),  32'd2);
    chk("nom_multihot", 32'(multi),    32'd0);
    chk("nom_prgm_b",   32'(end_prgm), 32'd1);
    @(negedge clk);
    chk("nom_idle_busy", 32'(m_busy),  32'd0);
    chk("nom_idle_done", 32'(m_done),  32'd0);
    chk("nom_error",     32'(m_error), 32'd0);

    // Source stall of 10 cycles before the second byte
    clear_chain();
    run_load(3, 1, 0, 0, 200);
    chk("stall_cycles",   32'(stall_cyc), 32'd10);
    chk("stall_fetch_en", 32'(fetch_en),  32'd0);
    chk("stall_seg0",     32'(cap_a[0]),  32'h0A53);
    chk("stall_seg1",     32'(cap_a[1]),  32'h0C0F);
    chk("stall_done",     32'(done_cnt),  32'd1);

    // Missing done on segment 1
    clear_chain();
    thr_a[1] = 1000;
    run_load(3, -1, 0, 0, 200);
    chk("miss_checks",  32'(chk_cyc),   32'd5);
    chk("miss_error",   32'(end_error), 32'd1);
    chk("miss_prgm_b",  32'(end_prgm),  32'd1);
    chk("miss_done",    32'(done_cnt),  32'd0);
    @(negedge clk);
    chk("miss_idle_busy",  32'(m_busy),  32'd0);
    chk("miss_error_held", 32'(m_error), 32'd1);
    thr_a[1] = 12;

    // Early done on segment 0 after 5 bits
    clear_chain();
    thr_a[0] = 5;
    run_load(3, -1, 0, 0, 200);
    chk("early_enables", 32'(en_cnt),    32'd6);
    chk("early_error",   32'(end_error), 32'd1);
    chk("early_busy",    32'(end_busy),  32'd1);
    en_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (m_seg != 4'd0) en_cnt++;
    end
    chk("early_quiet", 32'(en_cnt), 32'd0);
    thr_a[0] = 12;

    // Reset mid-load on the default instance
    sel = 1'b1;
    clear_chain();
    run_load(40, -1, 30, 0, 1000);
    @(negedge clk);
    check_reset_vals("midrst_b");
    reset = 1'b0;

    // Clean default load with an ignored start during SHIFT
    clear_chain();
    run_load(40, -1, 0, 100, 1000);
    chk("def_enables",  32'(en_cnt),    32'd320);
    chk("def_done",     32'(done_cnt),  32'd1);
    chk("def_checks",   32'(chk_cyc),   32'd4);
    chk("def_multihot", 32'(multi),     32'd0);
    chk("def_error",    32'(end_error), 32'd0);
    chk("def_prgm_b",   32'(end_prgm),  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cfg_chain_loader.md
# cfg_chain_loader

Sequencer that loads a configuration bitstream into the fabric's daisy-chained configuration segments: connection boxes, switch boxes and logic blocks. It accepts a byte stream through a valid/ready handshake and drives the global `prgm_b`. It serialises bits MSB-first into the shared `bit_out` line and enables exactly one segment at a time. It checks each segment's done flag before moving to the next. It sits between the bitstream source (host/UART/ROM reader) and the configuration chain.

## Interface
Parameters:
- `NUM_SEG`, 4: number of chained segments.
- `SEG_BITS`, 80: configuration bits per segment (identical for all segments).
- `DONE_TIMEOUT`, 4: maximum number of cycles to wait for a segment's done flag.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a load. Sampled only in IDLE.
- `data_in` in 8: bitstream byte.
- `data_valid` in 1: `data_in` is valid.
- `data_ready` out 1: loader accepts a byte this cycle.
- `seg_done_in` in `NUM_SEG`: per-segment done flag from the chain. A segment holds its flag high once it is loaded.
- `prgm_b` out 1: global program strobe. 0 = programming, 1 = operate.
- `seg_prgm_b` out `NUM_SEG`: per-segment shift enable. At most one bit is high.
- `bit_out` out 1: serial configuration bit.
- `busy` out 1: a load is in progress.
- `done` out 1: one-cycle pulse when the load completes.
- `error` out 1: sticky error flag. Cleared by `reset` or by an accepted `start`.

## Operation
- Reset values: `prgm_b`=1; `seg_prgm_b`=0; `bit_out`=0; `data_ready`=0; `busy`=0; `done`=0; `error`=0; state IDLE; all counters 0.
- States: IDLE, FETCH, SHIFT, CHECK, DONE, ERR.
- **IDLE**
  - On `start`=1: clear `error` and counters, go to FETCH.
  - `start` in any other state is ignored.
- **FETCH**
  - `data_ready`=1.
  - On `data_valid`=1: latch the byte, set bit index to 7, go to SHIFT.
  - While no byte arrives, stay in FETCH with all `seg_prgm_b`=0, so the chain stalls.
- **SHIFT**, one bit per cycle:
  - `bit_out` = byte[bit index] and `seg_prgm_b[seg]`=1.
  - The segment bit counter increments.
  - If this cycle shifts bit `SEG_BITS-1` of the segment, go to CHECK.
  - Otherwise, if bit index = 0, go to FETCH; else decrement the bit index.
- **CHECK**
  - `seg_prgm_b`=0. The timeout counter starts at 1 on entry.
  - If `seg_done_in[seg]`=1 and `seg`=`NUM_SEG-1`: go to DONE.
  - If `seg_done_in[seg]`=1 and more segments remain: increment `seg`, clear the segment bit counter, then:
    - if the current byte still has unshifted bits (bit index > 0), decrement the bit index and resume SHIFT;
    - otherwise go to FETCH.
  - If the counter reaches `DONE_TIMEOUT` without done: go to ERR.
- **Segment boundaries:** these need not align with byte boundaries; remaining bits of a byte continue into the next segment. Pad bits after the last segment's final bit are discarded.
- **Early done:** if `seg_done_in[seg]`=1 during SHIFT before the segment's final bit, go to ERR.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **ERR:** `error`=1. Go to IDLE next cycle; `error` stays set until cleared.
- `prgm_b`=0 in FETCH, SHIFT and CHECK; otherwise 1.
- `busy`=1 in every state except IDLE.
- **Reset mid-load:** immediate return to reset values on the next edge. Partial segment contents are not preserved by the loader.

## Timing
- `start` sampled at edge t: FETCH from t+1, so `prgm_b`=0 and `data_ready`=1 in cycle t+1.
- Byte accepted at edge t: its 8 bits appear in cycles t+1 … t+8 (bit 7 first). Next FETCH is at t+9.
  - Sustained throughput: 8 bits per 9 cycles.
- Final segment bit at cycle c: CHECK from c+1. A segment that flags done on its last enabled edge is seen at c+1.
- DONE cycle follows the CHECK cycle that sees the last done. `prgm_b` returns to 1 in the DONE cycle.
- `bit_out` and `seg_prgm_b` are registered outputs, changing only on `clk` edges.

## Structure
- Shared package `cfg_loader_pkg` holds:
  - the state enum;
  - default constants `SEG_BITS_DEFAULT`=80 and `DONE_TIMEOUT_DEFAULT`=4;
  - the counter widths: clog2 of `SEG_BITS` and of `NUM_SEG`.
- Sub-module `cfg_bit_serializer` holds the byte register, bit index and `bit_out`, with load/shift/empty signals. The FSM and counters live in the top.

## Test plan
- **Nominal load:** `NUM_SEG`=2, `SEG_BITS`=12, 3 bytes 0xA5,0x3C,0x0F, with a model chain asserting done after 12 enables.
  - Segment 0 receives 101001010011; segment 1 receives 110000001111.
  - Then `done` pulses once and `prgm_b` returns to 1.
- **Source stall:** `data_valid` held low for 10 cycles mid-load.
  - No `seg_prgm_b` bit is high during the stall; final contents are identical to the nominal load.
- **Missing done:** segment 1 never asserts done.
  - Exactly `DONE_TIMEOUT` CHECK cycles, then ERR; `error`=1 and `prgm_b`=1.
- **Early done:** segment 0 done forced high after 5 bits.
  - ERR on the next edge; no further `seg_prgm_b` activity.
- **Reset mid-load:** `reset` asserted after 30 shifted bits.
  - All outputs at reset values on the next edge; a subsequent `start` performs a clean full load.
- **Ignored start / default config:** `start` pulsed during SHIFT has no effect.
  - With default parameters (4×80 bits = 40 bytes), exactly 320 enable cycles occur and one `done` pulse.
